revlut_search: RTL and testbench

- Reverse-lookup engine for the programmable value table used by the index-to-value LUT path. Given a value, returns the lowest index whose entry equals it.
- Owns a register-based table of DEPTH entries, WIDTH bits each, plus a write port for reprogramming.
- Valid/ready request and response interfaces. Sits beside the forward LUT so control logic can recover an index from an observed code.

---
 rtl/revlut_pkg.sv | 21 ++
 rtl/revlut_search_if.sv | 32 +++
 rtl/revlut_prio_enc.sv | 23 ++
 rtl/revlut_search.sv | 134 +++++++++++++
 tb/tb_revlut_search.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/revlut_pkg.sv
// Shared types and defaults for the reverse-lookup table engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package revlut_pkg;

    localparam int DEF_LOG2_DEPTH = 3;
    localparam int DEF_WIDTH      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_e;

    // Entry j powers up holding j+1; callers truncate to the table width,
    // which gives the wrap modulo 2**WIDTH.
    function automatic logic [31:0] entry_init(input int unsigned j);
        return 32'(j + 1);
    endfunction

endpackage

// File: rtl/revlut_search_if.sv
// Write, request and response bundle for revlut_search.
// Latency: n/a (wiring only).
// Backpressure: req_ready/rsp_ready valid-ready pairs.
interface revlut_search_if #(
    parameter int LOG2_DEPTH = 3,
    parameter int WIDTH      = 8
);
    logic                  wr_en;
    logic [LOG2_DEPTH-1:0] wr_addr;
    logic [WIDTH-1:0]      wr_data;

    logic                  req_valid;
    logic                  req_ready;
    logic [WIDTH-1:0]      req_value;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [LOG2_DEPTH-1:0] rsp_index;
    logic                  rsp_hit;

    logic                  busy;

    modport master (
        output wr_en, wr_addr, wr_data, req_valid, req_value, rsp_ready,
        input  req_ready, rsp_valid, rsp_index, rsp_hit, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, req_valid, req_value, rsp_ready,
        output req_ready, rsp_valid, rsp_index, rsp_hit, busy
    );
endinterface

// File: rtl/revlut_prio_enc.sv
// Lowest-index priority encoder over a match vector.
// Latency: combinational.
// Backpressure: none.
module revlut_prio_enc #(
    parameter int DEPTH      = 8,
    parameter int LOG2_DEPTH = 3
) (
    input  logic [DEPTH-1:0]      match_vec,
    output logic [LOG2_DEPTH-1:0] idx,
    output logic                  any_hit
);

    // Walk high to low so the last assignment is the lowest set bit.
    always_comb begin
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_vec[i]) idx = LOG2_DEPTH'(i);
        end
    end

    assign any_hit = |match_vec;

endmodule

// File: rtl/revlut_search.sv
// Reverse lookup: returns the lowest table index holding a value. REVLUT_PARALLEL_SEARCH_EN selects the one-cycle search.
// Latency: hit at k -> k+1 cycles, miss -> DEPTH cycles (parallel build: 1 cycle either way).
// Backpressure: one search in flight; req_ready low until the response handshakes, result held while rsp_ready is low.
module revlut_search
    import revlut_pkg::*;
#(
    parameter int LOG2_DEPTH = DEF_LOG2_DEPTH,
    parameter int DEPTH      = 2 ** LOG2_DEPTH,
    parameter int WIDTH      = DEF_WIDTH
) (
    input logic            clock,
    input logic            reset,
    revlut_search_if.slave bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SCAN = SCAN;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]            state_q, state_d;
    logic [WIDTH-1:0]      target_q, target_d;
    logic [LOG2_DEPTH-1:0] rsp_index_q, rsp_index_d;
    logic                  rsp_hit_q, rsp_hit_d;
    logic [WIDTH-1:0]      table_q [DEPTH];
    logic [WIDTH-1:0]      table_d [DEPTH];

    logic                  accept;
    logic                  scan_done;
    logic                  scan_hit;
    logic [LOG2_DEPTH-1:0] scan_idx;

    assign accept = (state_q == ST_IDLE) && bus.req_valid;

`ifdef REVLUT_PARALLEL_SEARCH_EN
    logic [DEPTH-1:0] match_vec;

    always_comb begin
        match_vec = '0;
        for (int j = 0; j < DEPTH; j++) begin
            match_vec[j] = (table_q[j] == target_q);
        end
    end

    revlut_prio_enc #(
        .DEPTH      (DEPTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_prio_enc (
        .match_vec (match_vec),
        .idx       (scan_idx),
        .any_hit   (scan_hit)
    );

    assign scan_done = 1'b1;
`else
    logic [LOG2_DEPTH-1:0] idx_q, idx_d;

    assign scan_hit  = (table_q[idx_q] == target_q);
    assign scan_idx  = idx_q;
    // Termination is explicit at the last entry; idx never wraps.
    assign scan_done = scan_hit || (idx_q == LOG2_DEPTH'(DEPTH - 1));

    always_comb begin
        idx_d = idx_q;
        if (accept) begin
            idx_d = '0;
        end else if ((state_q == ST_SCAN) && !scan_done) begin
            idx_d = idx_q + LOG2_DEPTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) idx_q <= '0;
        else       idx_q <= idx_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        rsp_index_d = rsp_index_q;
        rsp_hit_d   = rsp_hit_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    target_d = bus.req_value;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_done) begin
                    rsp_index_d = scan_hit ? scan_idx : '0;
                    rsp_hit_d   = scan_hit;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                // Returning to IDLE here means req_ready rises only next cycle.
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Compares read table_q, so a same-cycle write is seen only afterwards.
    always_comb begin
        table_d = table_q;
        if (bus.wr_en) table_d[bus.wr_addr] = bus.wr_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            rsp_index_q <= '0;
            rsp_hit_q   <= 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                table_q[j] <= WIDTH'(entry_init(j));
            end
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            rsp_index_q <= rsp_index_d;
            rsp_hit_q   <= rsp_hit_d;
            table_q     <= table_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rsp_index = rsp_index_q;
    assign bus.rsp_hit   = rsp_hit_q;

endmodule

// File: tb/tb_revlut_search.sv
// Bench for revlut_search: directed scenarios plus randomized searches against a table model.
module tb_revlut_search;

    localparam int LOG2_DEPTH = 3;
    localparam int DEPTH      = 8;
    localparam int WIDTH      = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [WIDTH-1:0] model [DEPTH];

    revlut_search_if #(.LOG2_DEPTH(LOG2_DEPTH), .WIDTH(WIDTH)) bus ();

    revlut_search #(
        .LOG2_DEPTH (LOG2_DEPTH),
        .DEPTH      (DEPTH),
        .WIDTH      (WIDTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_init();
        for (int j = 0; j < DEPTH; j++) model[j] = WIDTH'(j + 1);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_init();
    endtask

    task automatic write_entry(input logic [LOG2_DEPTH-1:0] a, input logic [WIDTH-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
        model[a]    = d;
    endtask

    // Expected result: first table position equal to v; latency from the
    // acceptance edge is position+1 for a hit, the whole table for a miss.
    function automatic void ref_search(input logic [WIDTH-1:0] v, output int e_lat,
                                       output logic [LOG2_DEPTH-1:0] e_idx, output logic e_hit);
        bit found = 0;
        e_hit = 1'b0;
        e_idx = '0;
        e_lat = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && model[i] == v) begin
                found = 1;
                e_hit = 1'b1;
                e_idx = LOG2_DEPTH'(i);
                e_lat = i + 1;
            end
        end
`ifdef REVLUT_PARALLEL_SEARCH_EN
        e_lat = 1;
`endif
    endfunction

    // Issues a request from IDLE and waits (bounded) for rsp_valid.
    task automatic do_search(input logic [WIDTH-1:0] v, output int lat,
                             output logic [LOG2_DEPTH-1:0] idx, output logic hit, output logic busy_ok);
        bus.req_value = v;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (bus.rsp_valid !== 1'b1 && lat < 64) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        idx = bus.rsp_index;
        hit = bus.rsp_hit;
    endtask

    task automatic complete_rsp();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_index !== '0 ||
            bus.rsp_hit !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b vld=%b idx=%0d hit=%b busy=%b required 1 0 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_index, bus.rsp_hit, bus.busy);
        end
    endtask

    task automatic test_hit_first();
        int lat, e_lat; logic [LOG2_DEPTH-1:0] idx, e_idx; logic hit, e_hit, bz;
        apply_reset();
        ref_search(8'h01, e_lat, e_idx, e_hit);
        do_search(8'h01, lat, idx, hit, bz);
        checks++;
        if (lat !== e_lat || idx !== e_idx || hit !== e_hit) begin
            failures++;
            $display("FAIL hit_first got lat=%0d idx=%0d hit=%b required lat=%0d idx=%0d hit=%b",
                     lat, idx, hit, e_lat, e_idx, e_hit);
        end
        complete_rsp();
    endtask

    task automatic test_hit_last();
        int lat, e_lat; logic [LOG2_DEPTH-1:0] idx, e_idx; logic hit, e_hit, bz;
        apply_reset();
        ref_search(8'h08, e_lat, e_idx, e_hit);
        do_search(8'h08, lat, idx, hit, bz);
        checks++;
        if (lat !== e_lat || idx !== e_idx || hit !== e_hit) begin
            failures++;
            $display("FAIL hit_last got lat=%0d idx=%0d hit=%b required lat=%0d idx=%0d hit=%b",
                     lat, idx, hit, e_lat, e_idx, e_hit);
        end
        complete_rsp();
    endtask

    task automatic test_miss();
        int lat, e_lat; logic [LOG2_DEPTH-1:0] idx, e_idx; logic hit, e_hit, bz;
        apply_reset();
        ref_search(8'h00, e_lat, e_idx, e_hit);
        do_search(8'h00, lat, idx, hit, bz);
        checks++;
        if (lat !== e_lat || idx !== e_idx || hit !== e_hit) begin
            failures++;
            $display("FAIL miss got lat=%0d idx=%0d hit=%b required lat=%0d idx=%0d hit=%b",
                     lat, idx, hit, e_lat, e_idx, e_hit);
        end
        checks++;
        if (bz !== 1'b1) begin
            failures++;
            $display("FAIL miss_busy got busy_throughout=%b required 1", bz);
        end
        complete_rsp();
    endtask

    task automatic test_duplicates();
        int lat, e_lat; logic [LOG2_DEPTH-1:0] idx, e_idx; logic hit, e_hit, bz;
        apply_reset();
        write_entry(3'd5, 8'h03);
        ref_search(8'h03, e_lat, e_idx, e_hit);
        do_search(8'h03, lat, idx, hit, bz);
        checks++;
        if (idx !== 3'd2 || e_idx !== 3'd2 || hit !== 1'b1 || lat !== e_lat) begin
            failures++;
            $display("FAIL dup_lowest got lat=%0d idx=%0d hit=%b required lat=%0d idx=2 hit=1",
                     lat, idx, hit, e_lat);
        end
        complete_rsp();
        write_entry(3'd2, 8'h55);
        ref_search(8'h03, e_lat, e_idx, e_hit);
        do_search(8'h03, lat, idx, hit, bz);
        checks++;
        if (idx !== 3'd5 || hit !== 1'b1 || lat !== e_lat) begin
            failures++;
            $display("FAIL dup_after_overwrite got lat=%0d idx=%0d hit=%b required lat=%0d idx=5 hit=1",
                     lat, idx, hit, e_lat);
        end
        complete_rsp();
    endtask

    task automatic test_backpressure();
        int lat; logic [LOG2_DEPTH-1:0] idx; logic hit, bz, stable;
        apply_reset();
        do_search(8'h03, lat, idx, hit, bz);
        stable = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_value = 8'h01;
        for (int c = 0; c < 4; c++) begin
            if (bus.rsp_valid !== 1'b1 || bus.rsp_index !== 3'd2 || bus.rsp_hit !== 1'b1 ||
                bus.req_ready !== 1'b0) stable = 1'b0;
            tick();
        end
        checks++;
        if (stable !== 1'b1 || bus.rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_stable got vld=%b idx=%0d hit=%b rdy=%b required 1 2 1 0",
                     bus.rsp_valid, bus.rsp_index, bus.rsp_hit, bus.req_ready);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL release_idle got rdy=%b vld=%b busy=%b required 1 0 0",
                     bus.req_ready, bus.rsp_valid, bus.busy);
        end
        bus.req_valid = 1'b0;
    endtask

`ifndef REVLUT_PARALLEL_SEARCH_EN
    task automatic test_write_during_scan();
        int lat; logic [LOG2_DEPTH-1:0] idx; logic hit;
        apply_reset();
        // Entry 6 rewritten before the scan reaches it: it must be found.
        bus.req_value = 8'h08;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        write_entry(3'd6, 8'h08);
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 64) begin tick(); lat++; end
        checks++;
        if (lat !== 7 || bus.rsp_index !== 3'd6 || bus.rsp_hit !== 1'b1) begin
            failures++;
            $display("FAIL write_ahead got lat=%0d idx=%0d hit=%b required lat=7 idx=6 hit=1",
                     lat, bus.rsp_index, bus.rsp_hit);
        end
        complete_rsp();
        // Entry 2 rewritten while being compared, entry 0 after being passed.
        bus.req_value = 8'h42;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        write_entry(3'd0, 8'h42);
        write_entry(3'd2, 8'h42);
        lat = 3;
        while (bus.rsp_valid !== 1'b1 && lat < 64) begin tick(); lat++; end
        checks++;
        if (lat !== DEPTH || bus.rsp_index !== 3'd0 || bus.rsp_hit !== 1'b0) begin
            failures++;
            $display("FAIL write_behind got lat=%0d idx=%0d hit=%b required lat=%0d idx=0 hit=0",
                     lat, bus.rsp_index, bus.rsp_hit, DEPTH);
        end
        complete_rsp();
    endtask
`endif

    task automatic test_reset_mid_scan();
        int lat, e_lat; logic [LOG2_DEPTH-1:0] idx, e_idx; logic hit, e_hit, bz, quiet;
        apply_reset();
        write_entry(3'd0, 8'h77);
        bus.req_value = 8'h08;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_index !== '0 ||
            bus.rsp_hit !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs got rdy=%b vld=%b idx=%0d hit=%b busy=%b required 1 0 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_index, bus.rsp_hit, bus.busy);
        end
        reset = 1'b0;
        model_init();
        quiet = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
            tick();
        end
        checks++;
        if (quiet !== 1'b1) begin
            failures++;
            $display("FAIL abort_no_response got quiet=%b required 1", quiet);
        end
        for (int v = 1; v <= DEPTH; v++) begin
            ref_search(WIDTH'(v), e_lat, e_idx, e_hit);
            do_search(WIDTH'(v), lat, idx, hit, bz);
            checks++;
            if (lat !== e_lat || idx !== e_idx || hit !== e_hit || idx !== LOG2_DEPTH'(v - 1)) begin
                failures++;
                $display("FAIL table_restored v=%0d got lat=%0d idx=%0d hit=%b required lat=%0d idx=%0d hit=1",
                         v, lat, idx, hit, e_lat, v - 1);
            end
            complete_rsp();
        end
    endtask

    task automatic test_random();
        int lat, e_lat; logic [LOG2_DEPTH-1:0] idx, e_idx; logic hit, e_hit, bz;
        logic [WIDTH-1:0] v;
        apply_reset();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1)
                write_entry(LOG2_DEPTH'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom_range(0, 15)));
            v = WIDTH'($urandom_range(0, 15));
            ref_search(v, e_lat, e_idx, e_hit);
            do_search(v, lat, idx, hit, bz);
            checks++;
            if (lat !== e_lat || idx !== e_idx || hit !== e_hit || bz !== 1'b1) begin
                failures++;
                $display("FAIL random n=%0d v=%0h got lat=%0d idx=%0d hit=%b busy=%b required lat=%0d idx=%0d hit=%b busy=1",
                         n, v, lat, idx, hit, bz, e_lat, e_idx, e_hit);
            end
            for (int w = $urandom_range(0, 2); w > 0; w--) tick();
            complete_rsp();
        end
    endtask

    initial begin
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.req_valid = 1'b0;
        bus.req_value = '0;
        bus.rsp_ready = 1'b0;
        tick();
        test_reset();
        test_hit_first();
        test_hit_last();
        test_miss();
        test_duplicates();
        test_backpressure();
`ifndef REVLUT_PARALLEL_SEARCH_EN
        test_write_during_scan();
`endif
        test_reset_mid_scan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
